// File: rtl/score_keeper.sv
// score_keeper: per-frame score/bomb bookkeeping for the shooter game
//   clk_vga              pixel clock, all state on rising edge
//   rst                  asynchronous active-high reset
//   game_status_i        PRERUN / RUN / OVER game phase
//   frame_start_i        one-cycle pulse at the first cycle of each frame
//   crash_enemy_bullet_i per-pixel bullet/enemy overlap
//   crash_me_bonus_i     per-pixel plane/bonus overlap
//   bomb_use_i           one-cycle bomb request
//   score_bcd_o          current score, 4 BCD digits
//   high_score_bcd_o     best score since reset, 4 BCD digits
//   bomb_cnt_o           bomb stock
//   bomb_o               one-cycle pulse when a bomb fires
//   enemy_hit_o          one-cycle pulse per frame with any enemy hit
module score_keeper #(
  parameter int SCORE_INC = 1,
  parameter int BOMB_MAX = 3,
  parameter int BOMB_INIT = 1,
  parameter int GAME_STATUS_BIT_LEN = 2,
  parameter logic [GAME_STATUS_BIT_LEN-1:0] PRERUN = 0,
  parameter logic [GAME_STATUS_BIT_LEN-1:0] RUN = 1,
  parameter logic [GAME_STATUS_BIT_LEN-1:0] OVER = 2
) (
  input  logic                           clk_vga,
  input  logic                           rst,
  input  logic [GAME_STATUS_BIT_LEN-1:0] game_status_i,
  input  logic                           frame_start_i,
  input  logic                           crash_enemy_bullet_i,
  input  logic                           crash_me_bonus_i,
  input  logic                           bomb_use_i,
  output logic [15:0]                    score_bcd_o,
  output logic [15:0]                    high_score_bcd_o,
  output logic [1:0]                     bomb_cnt_o,
  output logic                           bomb_o,
  output logic                           enemy_hit_o
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t state, state_nx;
  logic hit_flag, bonus_flag, hit_nx, bonus_nx;
  logic stay, start, commit, fire;
  logic [16:0] sum;
  logic [15:0] score_nx, high_nx;
  logic [1:0] stock_up, bomb_nx;
  // Digit-serial BCD add; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] inc);
    logic [4:0] d;
    logic c;
    logic [15:0] r;
    c = 1'b0;
    r = a;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {4'd0, c} + (i == 0 ? {1'b0, inc} : 5'd0);
      c = d > 5'd9;
      r[4*i +: 4] = c ? 4'(d - 5'd10) : d[3:0];
    end
    return {c, r};
  endfunction
  always_ff @(posedge clk_vga or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = game_status_i == PRERUN ? IDLE :
               (state == IDLE && game_status_i == RUN) ? PLAY :
               (state == PLAY && game_status_i == OVER) ? DONE : state;
    // Flags and commits live only while PLAY persists, so the game-ending
    // cycle never commits and pending flags are dropped.
    stay = state == PLAY && state_nx == PLAY;
    start = state == IDLE && state_nx == PLAY;
    commit = stay && frame_start_i;
    fire = stay && bomb_use_i && bomb_cnt_o != 2'd0;
    sum = bcd_add(score_bcd_o, 4'(SCORE_INC));
    // A crash on the frame_start cycle seeds the new frame's flag.
    hit_nx = stay && ((hit_flag && !frame_start_i) || crash_enemy_bullet_i);
    bonus_nx = stay && ((bonus_flag && !frame_start_i) || crash_me_bonus_i);
    score_nx = start ? 16'h0000 : (commit && hit_flag) ? (sum[16] ? 16'h9999 : sum[15:0]) : score_bcd_o;
    stock_up = (commit && bonus_flag && bomb_cnt_o != 2'(BOMB_MAX)) ? bomb_cnt_o + 2'd1 : bomb_cnt_o;
    bomb_nx = start ? 2'(BOMB_INIT) : stock_up - {1'b0, fire};
    // Packed BCD orders the same as binary, so a plain compare suffices.
    high_nx = (state == PLAY && state_nx == DONE && score_bcd_o > high_score_bcd_o) ? score_bcd_o : high_score_bcd_o;
  end
  always_ff @(posedge clk_vga or posedge rst)
    if (rst) begin
      hit_flag <= 1'b0;
      bonus_flag <= 1'b0;
      score_bcd_o <= 16'h0000;
      high_score_bcd_o <= 16'h0000;
      bomb_cnt_o <= 2'd0;
      bomb_o <= 1'b0;
      enemy_hit_o <= 1'b0;
    end else begin
      hit_flag <= hit_nx;
      bonus_flag <= bonus_nx;
      score_bcd_o <= score_nx;
      high_score_bcd_o <= high_nx;
      bomb_cnt_o <= bomb_nx;
      bomb_o <= fire;
      enemy_hit_o <= commit && hit_flag;
    end
endmodule
